cam_pixel_fifo: RTL and testbench
=================================

CAM_PIXEL_FIFO -- requirements
Module: cam_pixel_fifo

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, giving the pixel data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 9, giving FIFO depth DEPTH = 2^ADDR_W words.
REQ-003 The block SHALL have parameter HBLANK_CYC, default 16, giving the idle pclk cycles that declare horizontal blank.
REQ-004 The block SHALL have parameter VBLANK_CYC, default 1024, giving the idle pclk cycles that declare vertical blank; VBLANK_CYC > HBLANK_CYC.
REQ-005 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port pix_valid, input, 1 bit: camera data valid (href).
REQ-008 The block SHALL have port camD, input, PIX_W bits: camera pixel data.
REQ-009 The block SHALL have port rd_en, input, 1 bit: consumer read request.
REQ-010 The block SHALL have port ovf_clr, input, 1 bit: clears the overflow flag.
REQ-011 The block SHALL have port rd_data, output, PIX_W bits: read pixel.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-013 The block SHALL have ports empty and full, outputs, 1 bit each: FIFO status.
REQ-014 The block SHALL have port level, output, ADDR_W+1 bits: current word count, 0..DEPTH.
REQ-015 The block SHALL have port overflow, output, 1 bit: a write was dropped.
REQ-016 The block SHALL have ports hblank_stb and vblank_stb, outputs, 1 bit each: single-cycle blank strobes.

Function
REQ-017 The block SHALL accept a write when pix_valid=1 and full=0, storing camD at wr_ptr and incrementing wr_ptr modulo DEPTH.
REQ-018 The block SHALL drop the write when pix_valid=1 and full=1; the stored data and wr_ptr SHALL remain unchanged.
REQ-019 The block SHALL accept a read when rd_en=1 and empty=0, incrementing rd_ptr modulo DEPTH.
REQ-020 The block SHALL present the read word on rd_data with rd_valid=1 exactly one cycle after an accepted read; rd_data SHALL hold its value otherwise.
REQ-021 The block SHALL ignore rd_en=1 when empty=1, leaving rd_valid=0 on the next cycle.
REQ-022 The block SHALL evaluate write and read acceptance against the full and empty values registered at the start of the cycle; a simultaneous accepted write and read SHALL leave level unchanged.
REQ-023 The block SHALL update level by +1 for a write alone, -1 for a read alone, and 0 otherwise, with full = (level==DEPTH) and empty = (level==0).
REQ-024 The block SHALL keep a saturating idle counter that clears on pix_valid=1 and increments on each pix_valid=0 cycle.
REQ-025 The block SHALL assert hblank_stb for exactly one cycle when the idle counter reaches HBLANK_CYC.
REQ-026 The block SHALL assert vblank_stb for exactly one cycle when the idle counter reaches VBLANK_CYC.
REQ-027 The block SHALL NOT re-strobe either blank signal until pix_valid has been seen high again.

Reset
REQ-028 The block SHALL, while rstn=0, asynchronously force wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, hblank_stb=0, vblank_stb=0 and idle counter=0.
REQ-029 The block SHALL, on reset assertion mid-operation, discard all buffered data, with RAM contents don't-care.
REQ-030 The block SHALL accept the first write on the first rising pclk edge after rstn deasserts.

Configuration
REQ-031 The block SHALL, when macro CAM_FIFO_STICKY_OVF_EN is defined, set overflow on any dropped write and hold it until a cycle with ovf_clr=1; a drop in the same cycle as ovf_clr=1 SHALL leave overflow=1.
REQ-032 The block SHALL, when CAM_FIFO_STICKY_OVF_EN is undefined, assert overflow for exactly one cycle following each dropped write, and ovf_clr SHALL have no effect.

Verification
REQ-033 The bench SHALL cover: reset, then 5 writes (0x11..0x15), then 5 reads -> rd_data 0x11..0x15 each one cycle after rd_en, level 5->0, and empty=1.
REQ-034 The bench SHALL cover: with ADDR_W=9, 512 writes then 1 more -> full=1, level=512, that write dropped, and overflow=1 (held until ovf_clr when sticky, one cycle otherwise).
REQ-035 The bench SHALL cover: with level=512, simultaneous pix_valid and rd_en -> read accepted, write dropped, level=511.
REQ-036 The bench SHALL cover: with level=3, simultaneous write and read for 600 cycles -> level stays 3, pointers wrap, and data order is preserved.
REQ-037 The bench SHALL cover: pix_valid low for 1100 cycles -> one hblank_stb at idle cycle 16, one vblank_stb at idle cycle 1024, and no further strobes.
REQ-038 The bench SHALL cover: rstn pulsed low with level=100 -> empty=1, level=0, and rd_valid=0 immediately; rd_en afterwards yields no rd_valid.

Source files
------------

// File: rtl/cam_pixel_fifo.sv
// Camera pixel FIFO with blank-period detection on pclk.
// CAM_FIFO_STICKY_OVF_EN: when defined, overflow is held until ovf_clr; otherwise it is a one-cycle pulse.
module cam_pixel_fifo #(
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 9,
  parameter int HBLANK_CYC = 16,
  parameter int VBLANK_CYC = 1024
) (
  input  logic              pclk,
  input  logic              rstn,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  camD,
  input  logic              rd_en,
  input  logic              ovf_clr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              hblank_stb,
  output logic              vblank_stb
);

  // state     | meaning
  // BL_ACTIVE | pixels seen recently, counting idle cycles toward hblank
  // BL_HBLANK | hblank declared, counting idle cycles toward vblank
  // BL_VBLANK | vblank declared, waiting for pix_valid to rearm

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int IDLE_W = $clog2(VBLANK_CYC + 1);
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_H     = IDLE_W'(HBLANK_CYC);
  localparam logic [IDLE_W-1:0] IDLE_V     = IDLE_W'(VBLANK_CYC);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

  typedef enum logic [1:0] {
    BL_ACTIVE = 2'd0,
    BL_HBLANK = 2'd1,
    BL_VBLANK = 2'd2
  } blank_state_t;

  logic [PIX_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              wrAcc;
  logic              rdAcc;
  logic              dropWr;

  logic [IDLE_W-1:0] idleCnt;
  logic [IDLE_W-1:0] idleNext;
  blank_state_t      blankState;
  blank_state_t      blankNext;
  logic              hbSet;
  logic              vbSet;

  // Flags come straight from the registered level, so acceptance always
  // sees the occupancy from the start of the cycle.
  assign empty  = (level == '0);
  assign full   = (level == LEVEL_FULL);
  assign wrAcc  = pix_valid & ~full;
  assign dropWr = pix_valid & full;
  assign rdAcc  = rd_en & ~empty;

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge pclk) begin
    if (wrAcc) begin
      mem[wrPtr] <= camD;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (wrAcc) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (rdAcc) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      case ({wrAcc, rdAcc})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rdAcc;
      if (rdAcc) begin
        rd_data <= mem[rdPtr];
      end
    end
  end

`ifdef CAM_FIFO_STICKY_OVF_EN
  // A drop wins over a clear landing in the same cycle.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (dropWr) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unusedOvfClr;
  assign unusedOvfClr = ovf_clr;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else begin
      overflow <= dropWr;
    end
  end
`endif

  // Idle counter saturates at the vblank threshold so neither strobe can repeat.
  always_comb begin
    idleNext = idleCnt;
    if (pix_valid) begin
      idleNext = '0;
    end else if (idleCnt != IDLE_V) begin
      idleNext = idleCnt + IDLE_ONE;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      blankState <= BL_ACTIVE;
      idleCnt    <= '0;
      hblank_stb <= 1'b0;
      vblank_stb <= 1'b0;
    end else begin
      blankState <= blankNext;
      idleCnt    <= idleNext;
      hblank_stb <= hbSet;
      vblank_stb <= vbSet;
    end
  end

  always_comb begin
    blankNext = blankState;
    hbSet     = 1'b0;
    vbSet     = 1'b0;
    if (pix_valid) begin
      blankNext = BL_ACTIVE;
    end else begin
      case (blankState)
        BL_ACTIVE: begin
          if (idleNext == IDLE_H) begin
            blankNext = BL_HBLANK;
            hbSet     = 1'b1;
          end
        end
        BL_HBLANK: begin
          if (idleNext == IDLE_V) begin
            blankNext = BL_VBLANK;
            vbSet     = 1'b1;
          end
        end
        BL_VBLANK: blankNext = BL_VBLANK;
        default:   blankNext = BL_ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_fifo.sv
// Scoreboard bench for cam_pixel_fifo: stimulus queues expected reads, a negedge monitor checks them.
module tb_cam_pixel_fifo;

  logic       pclk;
  logic       rstn;
  logic       pix_valid;
  logic [7:0] camD;
  logic       rd_en;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [9:0] level;
  logic       overflow;
  logic       hblank_stb;
  logic       vblank_stb;

  cam_pixel_fifo dut (
    .pclk(pclk), .rstn(rstn), .pix_valid(pix_valid), .camD(camD),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .hblank_stb(hblank_stb), .vblank_stb(vblank_stb)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] model[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One cycle of stimulus; acceptance is judged on occupancy before the edge.
  task automatic doCycle(input logic wr, input logic [7:0] wdat, input logic rd);
    bit wasFull;
    bit wasEmpty;
    wasFull  = (model.size() == 512);
    wasEmpty = (model.size() == 0);
    pix_valid = wr;
    camD      = wdat;
    rd_en     = rd;
    if (rd && !wasEmpty) begin
      exp_t e;
      e.data = model.pop_front();
      e.cyc  = cyc + 1;
      expQ.push_back(e);
    end
    if (wr && !wasFull) model.push_back(wdat);
    step();
    pix_valid = 1'b0;
    rd_en     = 1'b0;
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (rstn) begin
      if (rd_valid) begin
        if (expQ.size() == 0) begin
          chk("rd_unexpected", {31'd0, rd_valid}, 32'd0);
        end else begin
          e = expQ.pop_front();
          chk("rd_data", {24'd0, rd_data}, {24'd0, e.data});
          chk("rd_latency", cyc, e.cyc);
        end
      end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        chk("rd_missing", {31'd0, rd_valid}, 32'd1);
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b0; pix_valid = 1'b0; camD = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();

    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {22'd0, level}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_hblank", {31'd0, hblank_stb}, 32'd0);
    chk("rst_vblank", {31'd0, vblank_stb}, 32'd0);
    rstn = 1'b1;

    // Five writes then five reads.
    for (int i = 0; i < 5; i++) begin
      doCycle(1'b1, 8'(8'h11 + i), 1'b0);
      chk("wr5_level", {22'd0, level}, 32'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      doCycle(1'b0, 8'h00, 1'b1);
      chk("rd5_level", {22'd0, level}, 32'(4 - i));
    end
    chk("rd5_empty", {31'd0, empty}, 32'd1);
    step();

    // Fill to 512, then one dropped write.
    for (int i = 0; i < 512; i++) doCycle(1'b1, i[7:0], 1'b0);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_level", {22'd0, level}, 32'd512);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);
    doCycle(1'b1, 8'hAA, 1'b0);
    chk("drop_full", {31'd0, full}, 32'd1);
    chk("drop_level", {22'd0, level}, 32'd512);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    step();
`ifdef CAM_FIFO_STICKY_OVF_EN
    chk("ovf_held", {31'd0, overflow}, 32'd1);
`else
    chk("ovf_pulse", {31'd0, overflow}, 32'd0);
`endif
    ovf_clr = 1'b1;
    doCycle(1'b1, 8'hCC, 1'b0);
    chk("drop_with_clr_ovf", {31'd0, overflow}, 32'd1);
    step();
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b0;

    // Full: simultaneous write and read -> read only.
    doCycle(1'b1, 8'hBB, 1'b1);
    chk("fullrw_level", {22'd0, level}, 32'd511);
    chk("fullrw_ovf", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    step();
    chk("fullrw_ovf_clr", {31'd0, overflow}, 32'd0);
    ovf_clr = 1'b0;

    for (int i = 0; i < 508; i++) doCycle(1'b0, 8'h00, 1'b1);
    chk("drain_level3", {22'd0, level}, 32'd3);

    // Streaming at level 3 wraps both pointers.
    for (int i = 0; i < 600; i++) begin
      doCycle(1'b1, 8'(8'h40 + i), 1'b1);
      chk("stream_level", {22'd0, level}, 32'd3);
    end
    for (int i = 0; i < 3; i++) doCycle(1'b0, 8'h00, 1'b1);
    chk("stream_empty", {31'd0, empty}, 32'd1);
    step();

    // Blank detection: one pixel, then 1100 idle cycles.
    doCycle(1'b1, 8'h77, 1'b0);
    for (int k = 1; k <= 1100; k++) begin
      step();
      chk("hblank_stb", {31'd0, hblank_stb}, (k == 16) ? 32'd1 : 32'd0);
      chk("vblank_stb", {31'd0, vblank_stb}, (k == 1024) ? 32'd1 : 32'd0);
    end

    // Reset with 100 words buffered.
    for (int i = 0; i < 99; i++) doCycle(1'b1, 8'(8'h80 + i), 1'b0);
    chk("pre_rst_level", {22'd0, level}, 32'd100);
    rstn = 1'b0;
    #1;
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_level", {22'd0, level}, 32'd0);
    chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("mid_rst_full", {31'd0, full}, 32'd0);
    model.delete();
    repeat (2) step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      doCycle(1'b0, 8'h00, 1'b1);
      chk("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("post_rst_level", {22'd0, level}, 32'd0);
    end
    step();
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
